// File: rtl/fcmp_pipe.sv
// Pipelined FloPoCo-format floating-point comparator with valid/ready handshake.
// One or two register stages; back-pressure freezes every stage together.
module fcmp_pipe #(
    parameter int WE     = 7,
    parameter int WF     = 7,
    parameter int TAG_W  = 4,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WE+WF+2:0]     x,
    input  logic [WE+WF+2:0]     y,
    input  logic [2:0]           op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 result,
    output logic                 lt,
    output logic                 eq,
    output logic                 gt,
    output logic                 unordered,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int W = WE + WF + 3;
    localparam int M = WE + WF;

    typedef enum logic [1:0] {
        EXN_ZERO = 2'b00,
        EXN_NORM = 2'b01,
        EXN_INF  = 2'b10,
        EXN_NAN  = 2'b11
    } exn_e;

    typedef enum logic [2:0] {
        OP_LT    = 3'd0,
        OP_LE    = 3'd1,
        OP_EQ    = 3'd2,
        OP_NE    = 3'd3,
        OP_GT    = 3'd4,
        OP_GE    = 3'd5,
        OP_UNORD = 3'd6,
        OP_ORD   = 3'd7
    } op_e;

    // Position on the number line: -inf, -normal, zero, +normal, +inf.
    function automatic logic [2:0] rank(input exn_e e, input logic s);
        case (e)
            EXN_NORM: rank = s ? 3'd1 : 3'd3;
            EXN_INF:  rank = s ? 3'd0 : 3'd4;
            default:  rank = 3'd2;
        endcase
    endfunction

    // Whole pipe advances together; the output register gates everything.
    logic adv;
    logic out_valid_q;

    assign adv      = rst_n & (~out_valid_q | out_ready);
    assign in_ready = adv;

    // Input decode (first half of the compare).
    exn_e             d_exn_x, d_exn_y;
    logic             d_sx, d_sy;
    logic             d_mag_lt, d_mag_gt;
    op_e              d_op;
    logic [TAG_W-1:0] d_tag;
    logic             d_valid;

    assign d_exn_x  = exn_e'(x[W-1 -: 2]);
    assign d_exn_y  = exn_e'(y[W-1 -: 2]);
    assign d_sx     = x[M];
    assign d_sy     = y[M];
    assign d_mag_lt = x[M-1:0] < y[M-1:0];
    assign d_mag_gt = x[M-1:0] > y[M-1:0];
    assign d_op     = op_e'(op);
    assign d_tag    = in_tag;
    assign d_valid  = in_valid;

    // Values feeding the combine step, registered or direct depending on depth.
    exn_e             c_exn_x, c_exn_y;
    logic             c_sx, c_sy;
    logic             c_mag_lt, c_mag_gt;
    op_e              c_op;
    logic [TAG_W-1:0] c_tag;
    logic             c_valid;

    if (STAGES == 2) begin : g_two
        exn_e             s1_exn_x_q, s1_exn_y_q;
        logic             s1_sx_q, s1_sy_q;
        logic             s1_mag_lt_q, s1_mag_gt_q;
        op_e              s1_op_q;
        logic [TAG_W-1:0] s1_tag_q;
        logic             s1_valid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
            end else if (adv) begin
                s1_valid_q <= d_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                s1_exn_x_q  <= d_exn_x;
                s1_exn_y_q  <= d_exn_y;
                s1_sx_q     <= d_sx;
                s1_sy_q     <= d_sy;
                s1_mag_lt_q <= d_mag_lt;
                s1_mag_gt_q <= d_mag_gt;
                s1_op_q     <= d_op;
                s1_tag_q    <= d_tag;
            end
        end

        assign c_exn_x  = s1_exn_x_q;
        assign c_exn_y  = s1_exn_y_q;
        assign c_sx     = s1_sx_q;
        assign c_sy     = s1_sy_q;
        assign c_mag_lt = s1_mag_lt_q;
        assign c_mag_gt = s1_mag_gt_q;
        assign c_op     = s1_op_q;
        assign c_tag    = s1_tag_q;
        assign c_valid  = s1_valid_q;
    end else if (STAGES == 1) begin : g_one
        assign c_exn_x  = d_exn_x;
        assign c_exn_y  = d_exn_y;
        assign c_sx     = d_sx;
        assign c_sy     = d_sy;
        assign c_mag_lt = d_mag_lt;
        assign c_mag_gt = d_mag_gt;
        assign c_op     = d_op;
        assign c_tag    = d_tag;
        assign c_valid  = d_valid;
    end else begin : g_bad
        $error("fcmp_pipe: STAGES must be 1 or 2");
    end

    // Combine step: relations plus predicate select.
    logic [2:0] rank_x, rank_y;
    logic       lt_d, eq_d, gt_d, unord_d, result_d;

    always_comb begin
        lt_d     = 1'b0;
        eq_d     = 1'b0;
        gt_d     = 1'b0;
        unord_d  = 1'b0;
        result_d = 1'b0;
        rank_x   = rank(c_exn_x, c_sx);
        rank_y   = rank(c_exn_y, c_sy);

        if (c_exn_x == EXN_NAN || c_exn_y == EXN_NAN) begin
            unord_d = 1'b1;
        end else if (rank_x < rank_y) begin
            lt_d = 1'b1;
        end else if (rank_x > rank_y) begin
            gt_d = 1'b1;
        end else if (rank_x == 3'd1) begin
            // Both negative normals: larger magnitude is the smaller value.
            lt_d = c_mag_gt;
            gt_d = c_mag_lt;
            eq_d = ~(c_mag_lt | c_mag_gt);
        end else if (rank_x == 3'd3) begin
            lt_d = c_mag_lt;
            gt_d = c_mag_gt;
            eq_d = ~(c_mag_lt | c_mag_gt);
        end else begin
            eq_d = 1'b1;
        end

        case (c_op)
            OP_LT:    result_d = lt_d;
            OP_LE:    result_d = lt_d | eq_d;
            OP_EQ:    result_d = eq_d;
            OP_NE:    result_d = ~eq_d;
            OP_GT:    result_d = gt_d;
            OP_GE:    result_d = gt_d | eq_d;
            OP_UNORD: result_d = unord_d;
            OP_ORD:   result_d = ~unord_d;
            default:  result_d = 1'b0;
        endcase
    end

    // Output register.
    logic             result_q, lt_q, eq_q, gt_q, unord_q;
    logic [TAG_W-1:0] out_tag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            unord_q     <= 1'b0;
            out_tag_q   <= '0;
        end else if (adv) begin
            out_valid_q <= c_valid;
            result_q    <= result_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            unord_q     <= unord_d;
            out_tag_q   <= c_tag;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign unordered = unord_q;
    assign out_tag   = out_tag_q;

endmodule
